// File: rtl/counter_pkg.sv
// Shared definitions for the down counter: run-state encoding, prescaler/debounce widths and defaults,
// and the preset saturation rule.
package counter_pkg;

    localparam int DIV_W = 25;
    localparam int DEB_W = 20;

    localparam logic [DIV_W-1:0] DIV_MAX_DEFAULT    = 25'h1FFFFFF;
    localparam logic [DEB_W-1:0] DEB_CYCLES_DEFAULT = 20'd1000000;

    typedef enum logic {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } run_state_t;

    // Presets outside the count range clamp to the top of the sequence.
    function automatic logic [2:0] sat_load(input logic [2:0] val, input int mod);
        if (int'(val) >= mod) begin
            return 3'(mod - 1);
        end
        return val;
    endfunction

endpackage

// File: rtl/mod8_down_counter_if.sv
// Control and status bundle of the down counter: switch/button/preset in, count/borrow/segments out.
interface mod8_down_counter_if;

    logic       en;
    logic       load;
    logic [2:0] load_val;
    logic [2:0] q;
    logic       borrow;
    logic [6:0] display;

    modport master (output en, load, load_val, input q, borrow, display);
    modport slave  (input en, load, load_val, output q, borrow, display);

endinterface

// File: rtl/display7.sv
// Hex to 7-segment decoder, active-high segments ordered {g,f,e,d,c,b,a}.
module display7 (
    input  logic [3:0] value,
    output logic [6:0] segments
);

    always_comb begin
        segments = 7'h00;
        case (value)
            4'h0: segments = 7'h3F;
            4'h1: segments = 7'h06;
            4'h2: segments = 7'h5B;
            4'h3: segments = 7'h4F;
            4'h4: segments = 7'h66;
            4'h5: segments = 7'h6D;
            4'h6: segments = 7'h7D;
            4'h7: segments = 7'h07;
            4'h8: segments = 7'h7F;
            4'h9: segments = 7'h6F;
            4'hA: segments = 7'h77;
            4'hB: segments = 7'h7C;
            4'hC: segments = 7'h39;
            4'hD: segments = 7'h5E;
            4'hE: segments = 7'h79;
            4'hF: segments = 7'h71;
            default: segments = 7'h00;
        endcase
    end

endmodule

// File: rtl/mod8_down_counter_btn_cond.sv
// Input conditioning: 2-flop synchroniser, optional debounce (macro DEBOUNCE_EN), rising-edge pulse.
module btn_cond
    import counter_pkg::*;
#(
    parameter logic [DEB_W-1:0] DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise
);

    logic [1:0] sync;
    logic       last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 2'b00;
        end else begin
            sync <= {sync[0], raw};
        end
    end

`ifdef DEBOUNCE_EN
    logic [DEB_W-1:0] stable_cnt;
    logic             accepted;

    // The accepted level only follows the synchronised input after DEB_CYCLES disagreeing samples in a row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_cnt <= '0;
            accepted   <= 1'b0;
        end else if (sync[1] == accepted) begin
            stable_cnt <= '0;
        end else if (stable_cnt == DEB_CYCLES - 1'b1) begin
            stable_cnt <= '0;
            accepted   <= sync[1];
        end else begin
            stable_cnt <= stable_cnt + 1'b1;
        end
    end

    assign level = accepted;
`else
    assign level = sync[1];
`endif

    // last resets low, so a level already high at reset release still produces one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= 1'b0;
        end else begin
            last <= level;
        end
    end

    assign rise = level & ~last;

endmodule

// File: rtl/mod8_down_counter.sv
// Loadable modulo-MOD down counter with prescaled tick, borrow flag and 7-segment output.
// Optional macro DEBOUNCE_EN adds debouncing on the enable switch and load button.
module mod8_down_counter
    import counter_pkg::*;
#(
    parameter int               MOD        = 8,
    parameter logic [DIV_W-1:0] DIV_MAX    = DIV_MAX_DEFAULT,
    parameter logic [DEB_W-1:0] DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    mod8_down_counter_if.slave  bus
);

    localparam logic [2:0] TOP = 3'(MOD - 1);

    logic             en_level;
    logic             load_p;
    run_state_t       state;
    run_state_t       next_state;
    logic [DIV_W-1:0] prescale;
    logic             tick;
    logic [2:0]       count;
    logic             borrow;

    btn_cond #(.DEB_CYCLES(DEB_CYCLES)) en_cond (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (bus.en),
        .level (en_level),
        .rise  ()
    );

    btn_cond #(.DEB_CYCLES(DEB_CYCLES)) load_cond (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (bus.load),
        .level (),
        .rise  (load_p)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= STOPPED;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            STOPPED: if (en_level)  next_state = RUNNING;
            RUNNING: if (!en_level) next_state = STOPPED;
            default: next_state = STOPPED;
        endcase
    end

    assign tick = (state == RUNNING) && (prescale == DIV_MAX);

    // Counting starts on the cycle the enable is seen, so the first tick lands DIV_MAX+1 edges after it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescale <= '0;
        end else if ((next_state == STOPPED) || load_p || tick) begin
            prescale <= '0;
        end else begin
            prescale <= prescale + 1'b1;
        end
    end

    // A load on a tick cycle swallows the tick, including its borrow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= 3'd0;
            borrow <= 1'b0;
        end else if (load_p) begin
            count  <= sat_load(bus.load_val, MOD);
            borrow <= 1'b0;
        end else if (tick) begin
            count  <= (count == 3'd0) ? TOP : count - 1'b1;
            borrow <= (count == 3'd0);
        end else begin
            borrow <= 1'b0;
        end
    end

    assign bus.q      = count;
    assign bus.borrow = borrow;

    display7 seg_dec (
        .value    ({1'b0, count}),
        .segments (bus.display)
    );

endmodule

// File: tb/tb_mod8_down_counter.sv
// Self-checking bench: MOD=8 and MOD=6 counters driven in parallel against a cycle-level reference model.
module tb_mod8_down_counter;
    import counter_pkg::*;

    localparam logic [DIV_W-1:0] TB_DIV_MAX = 25'd3;
    localparam logic [DEB_W-1:0] TB_DEB     = 20'd4;

    logic clk = 1'b0;
    logic rst_n;

    mod8_down_counter_if bus8 ();
    mod8_down_counter_if bus6 ();

    mod8_down_counter #(.MOD(8), .DIV_MAX(TB_DIV_MAX), .DEB_CYCLES(TB_DEB)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    mod8_down_counter #(.MOD(6), .DIV_MAX(TB_DIV_MAX), .DEB_CYCLES(TB_DEB)) dut6 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus6)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [6:0] seg [8] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07};
    int         mods [2] = '{8, 6};

    // Reference model state: delayed raw inputs, counted cycles since last clear, counts and borrows.
    bit m_e1, m_e2, m_l1, m_l2, m_last;
    bit m_ea, m_la;
    int m_ec, m_lc;
    int m_ph;
    int m_q [2];
    bit m_b [2];

    function automatic int exp_load(input int val, input int mod);
        return (val >= mod) ? mod - 1 : val;
    endfunction

    task automatic model_reset();
        m_e1 = 0; m_e2 = 0; m_l1 = 0; m_l2 = 0; m_last = 0;
        m_ea = 0; m_la = 0; m_ec = 0; m_lc = 0; m_ph = 0;
        for (int k = 0; k < 2; k++) begin
            m_q[k] = 0;
            m_b[k] = 0;
        end
    endtask

    task automatic model_edge();
        bit en_lvl, ld_lvl, load_p, tick;
`ifdef DEBOUNCE_EN
        en_lvl = m_ea;
        ld_lvl = m_la;
        if (m_e2 != m_ea) begin
            m_ec++;
            if (m_ec == int'(TB_DEB)) begin m_ea = m_e2; m_ec = 0; end
        end else m_ec = 0;
        if (m_l2 != m_la) begin
            m_lc++;
            if (m_lc == int'(TB_DEB)) begin m_la = m_l2; m_lc = 0; end
        end else m_lc = 0;
`else
        en_lvl = m_e2;
        ld_lvl = m_l2;
`endif
        load_p = ld_lvl && !m_last;
        tick   = (m_ph == int'(TB_DIV_MAX));
        for (int k = 0; k < 2; k++) begin
            if (load_p) begin
                m_q[k] = exp_load(int'(bus8.load_val), mods[k]);
                m_b[k] = 0;
            end else if (tick) begin
                m_b[k] = (m_q[k] == 0);
                m_q[k] = (m_q[k] == 0) ? mods[k] - 1 : m_q[k] - 1;
            end else begin
                m_b[k] = 0;
            end
        end
        m_ph   = (!en_lvl || load_p || tick) ? 0 : m_ph + 1;
        m_last = ld_lvl;
        m_e2 = m_e1; m_e1 = bus8.en;
        m_l2 = m_l1; m_l1 = bus8.load;
    endtask

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("[TB] FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    task automatic checkOutput(input string tag);
        check({tag, "_q8"},  8'(bus8.q),       8'(m_q[0]));
        check({tag, "_b8"},  8'(bus8.borrow),  8'(m_b[0]));
        check({tag, "_d8"},  8'(bus8.display), 8'(seg[m_q[0]]));
        check({tag, "_q6"},  8'(bus6.q),       8'(m_q[1]));
        check({tag, "_b6"},  8'(bus6.borrow),  8'(m_b[1]));
    endtask

    task automatic applyStimulus(input logic en, input logic load, input logic [2:0] val);
        bus8.en = en;  bus8.load = load;  bus8.load_val = val;
        bus6.en = en;  bus6.load = load;  bus6.load_val = val;
    endtask

    task automatic run_cycles(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            checkOutput(tag);
        end
    endtask

    task automatic timeout(input string tag);
        total++;
        bad++;
        $error("[TB] FAIL %s: condition not reached within bound", tag);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int  n;
        bit  en_r;

        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 3'd0);
        model_reset();
        repeat (2) @(negedge clk);
        checkOutput("reset");
        rst_n = 1'b1;

        // Free run: full 0,7,6..0,7 sequence with borrows.
        applyStimulus(1'b1, 1'b0, 3'd0);
        run_cycles(40, "t1_run");

        // Stop right after reaching 5, then re-enable.
        n = 0;
        while (m_q[0] != 5 && n < 40) begin run_cycles(1, "t2_seek"); n++; end
        if (m_q[0] != 5) timeout("t2_seek");
        applyStimulus(1'b0, 1'b0, 3'd0);
        run_cycles(12, "t2_hold");
        check("t2_held5", 8'(bus8.q), 8'd5);
        applyStimulus(1'b1, 1'b0, 3'd0);
`ifndef DEBOUNCE_EN
        run_cycles(5, "t2_rerun");
        check("t2_notyet", 8'(bus8.q), 8'd5);
        run_cycles(1, "t2_rerun");
        check("t2_first_dec", 8'(bus8.q), 8'd4);
`endif
        run_cycles(2, "t2_rerun");

        // Held button while stopped loads once; out-of-range preset saturates.
        applyStimulus(1'b0, 1'b0, 3'd0);
        run_cycles(6, "t3_stop");
        applyStimulus(1'b0, 1'b1, 3'd3);
`ifndef DEBOUNCE_EN
        run_cycles(2, "t3_load");
        check("t3_before_load", 8'(bus8.q), 8'(m_q[0]));
        run_cycles(1, "t3_load");
        check("t3_q8_is3", 8'(bus8.q), 8'd3);
        check("t3_q6_is3", 8'(bus6.q), 8'd3);
`endif
        run_cycles(17, "t3_held");
        applyStimulus(1'b0, 1'b0, 3'd3);
        run_cycles(3, "t3_rel");
        applyStimulus(1'b0, 1'b1, 3'd7);
`ifndef DEBOUNCE_EN
        run_cycles(3, "t3_sat");
        check("t3_q8_is7", 8'(bus8.q), 8'd7);
        check("t3_q6_is5", 8'(bus6.q), 8'd5);
`endif
        applyStimulus(1'b0, 1'b0, 3'd7);
        run_cycles(3, "t3_rel2");

        // Land a load pulse on the tick that would wrap 0 -> MOD-1.
        applyStimulus(1'b1, 1'b0, 3'd0);
        n = 0;
        while (!(m_q[0] == 0 && m_ph == 1) && n < 100) begin run_cycles(1, "t4_seek"); n++; end
        if (!(m_q[0] == 0 && m_ph == 1)) timeout("t4_seek");
        applyStimulus(1'b1, 1'b1, 3'd2);
        run_cycles(2, "t4_arm");
        applyStimulus(1'b1, 1'b0, 3'd2);
        run_cycles(1, "t4_collide");
`ifndef DEBOUNCE_EN
        check("t4_q_is2", 8'(bus8.q), 8'd2);
        check("t4_no_borrow", 8'(bus8.borrow), 8'd0);
        run_cycles(3, "t4_after");
        check("t4_still2", 8'(bus8.q), 8'd2);
        run_cycles(1, "t4_after");
        check("t4_dec_to1", 8'(bus8.q), 8'd1);
`endif

        // Asynchronous reset mid-count; button held through the reset release loads once.
        n = 0;
        while (m_q[0] != 4 && n < 100) begin run_cycles(1, "t5_seek"); n++; end
        if (m_q[0] != 4) timeout("t5_seek");
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_q",   8'(bus8.q),       8'd0);
        check("t5_async_b",   8'(bus8.borrow),  8'd0);
        check("t5_async_seg", 8'(bus8.display), 8'h3F);
        model_reset();
        applyStimulus(1'b1, 1'b1, 3'd6);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
`ifndef DEBOUNCE_EN
        run_cycles(3, "t5_reload");
        check("t5_q8_is6", 8'(bus8.q), 8'd6);
        check("t5_q6_is5", 8'(bus6.q), 8'd5);
`endif
        run_cycles(6, "t5_held");
        applyStimulus(1'b1, 1'b0, 3'd6);
        run_cycles(3, "t5_rel");

`ifdef DEBOUNCE_EN
        // Short glitch is ignored, longer press loads once.
        applyStimulus(1'b0, 1'b0, 3'd0);
        run_cycles(12, "t6_stop");
        applyStimulus(1'b0, 1'b1, 3'd1);
        run_cycles(3, "t6_glitch");
        applyStimulus(1'b0, 1'b0, 3'd1);
        run_cycles(12, "t6_glitch_rel");
        applyStimulus(1'b0, 1'b1, 3'd1);
        run_cycles(6, "t6_press");
        applyStimulus(1'b0, 1'b0, 3'd1);
        run_cycles(12, "t6_press_rel");
        check("t6_loaded1", 8'(bus8.q), 8'd1);
`endif

        // Randomised enable toggling, load pulses and presets.
        en_r = 1'b1;
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 15) == 0) en_r = ~en_r;
            applyStimulus(en_r, ($urandom_range(0, 9) == 0), 3'($urandom_range(0, 7)));
            run_cycles(1, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
